// File: rtl/sht40_sequencer.sv
// SHT40 measurement sequencer: triggers one i2c_master transaction, collects the
// six returned bytes, CRC-checks both words and publishes the raw readings or an
// error code.
module sht40_sequencer #(
    parameter logic [6:0]  SENSOR_ADDR    = 7'h44,
    parameter logic [7:0]  MEAS_CMD       = 8'hFD,
    parameter logic [23:0] MEAS_PERIOD    = 24'd12_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_400_000,
    parameter logic [3:0]  NUM_READS      = 4'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        meas_valid,
    output logic        meas_error,
    output logic [1:0]  err_code,
    output logic [15:0] temp_raw,
    output logic [15:0] rh_raw,
    output logic        proc_ready,
    output logic [6:0]  periph_addr,
    output logic [7:0]  cmd_frame,
    output logic        i2c_writes,
    output logic [3:0]  sht_reads,
    output logic        crc_error,
    input  logic [2:0]  master_state,
    input  logic [3:0]  bytes_received,
    input  logic [7:0]  data_received
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_ACTIVE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CRC     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_SHORT   = 2'b11;

    localparam logic [2:0] MST_IDLE = 3'b000;

    state_t      state;
    logic [23:0] period_cnt;
    logic [23:0] tmo_cnt;
    logic [3:0]  prev_cnt;
    logic [2:0]  byte_idx;
    logic [7:0]  byte_q [6];
    logic [1:0]  err_pend;

    logic        period_hit;
    logic        timeout_hit;
    logic        byte_evt;
    logic        store;
    logic [2:0]  idx_next;
    logic        crc_fail;
    logic [7:0]  crc_calc;

    // CRC-8, poly 0x31, init 0xFF, MSB first over one 16-bit word
    function automatic logic [7:0] crc8_word(input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0]  crc;
        logic [15:0] data;
        logic        fb;
        crc  = 8'hFF;
        data = {hi, lo};
        for (int unsigned i = 0; i < 16; i++) begin
            fb   = crc[7] ^ data[15];
            crc  = {crc[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
            data = {data[14:0], 1'b0};
        end
        return crc;
    endfunction

    assign periph_addr = SENSOR_ADDR;
    assign cmd_frame   = MEAS_CMD;
    assign i2c_writes  = 1'b1;
    assign sht_reads   = NUM_READS;

    assign period_hit  = (MEAS_PERIOD != '0) && (period_cnt == MEAS_PERIOD - 24'd1);
    assign timeout_hit = (tmo_cnt == TIMEOUT_CYCLES);

    // Byte arrival detection, index advance and CRC check of the word just completed
    always_comb begin
        byte_evt = (bytes_received != prev_cnt);
        store    = byte_evt && (byte_idx < 3'd6);
        idx_next = store ? byte_idx + 3'd1 : byte_idx;
        crc_calc = (byte_idx == 3'd2) ? crc8_word(byte_q[0], byte_q[1])
                                      : crc8_word(byte_q[3], byte_q[4]);
        crc_fail = store && ((byte_idx == 3'd2) || (byte_idx == 3'd5)) &&
                   (crc_calc != data_received);
    end

    // Free-running auto-trigger period counter, active in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (MEAS_PERIOD == '0 || period_hit) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 24'd1;
        end
    end

    // Measurement FSM with registered control and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            meas_error <= 1'b0;
            err_code   <= ERR_NONE;
            temp_raw   <= '0;
            rh_raw     <= '0;
            proc_ready <= 1'b0;
            crc_error  <= 1'b0;
            tmo_cnt    <= '0;
            prev_cnt   <= '0;
            byte_idx   <= '0;
            err_pend   <= ERR_NONE;
            for (int unsigned i = 0; i < 6; i++) begin
                byte_q[i] <= '0;
            end
        end else begin
            meas_valid <= 1'b0;
            meas_error <= 1'b0;
            crc_error  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || period_hit) begin
                        state      <= S_REQUEST;
                        busy       <= 1'b1;
                        proc_ready <= 1'b1;
                        prev_cnt   <= bytes_received;
                        byte_idx   <= '0;
                        tmo_cnt    <= '0;
                    end
                end
                S_REQUEST: begin
                    tmo_cnt <= tmo_cnt + 24'd1;
                    if (timeout_hit) begin
                        proc_ready <= 1'b0;
                        err_pend   <= ERR_TIMEOUT;
                        state      <= S_ERROR;
                    end else if (master_state != MST_IDLE) begin
                        proc_ready <= 1'b0;
                        state      <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    tmo_cnt <= tmo_cnt + 24'd1;
                    if (byte_evt) begin
                        prev_cnt <= bytes_received;
                    end
                    if (store) begin
                        byte_q[byte_idx] <= data_received;
                        byte_idx         <= idx_next;
                    end
                    // CRC failure beats completion, completion beats timeout
                    if (crc_fail) begin
                        crc_error <= 1'b1;
                        err_pend  <= ERR_CRC;
                        state     <= S_ERROR;
                    end else if (master_state == MST_IDLE) begin
                        if (idx_next == 3'd6) begin
                            state <= S_DONE;
                        end else begin
                            err_pend <= ERR_SHORT;
                            state    <= S_ERROR;
                        end
                    end else if (timeout_hit) begin
                        err_pend <= ERR_TIMEOUT;
                        state    <= S_ERROR;
                    end
                end
                S_DONE: begin
                    temp_raw   <= {byte_q[0], byte_q[1]};
                    rh_raw     <= {byte_q[3], byte_q[4]};
                    err_code   <= ERR_NONE;
                    meas_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                S_ERROR: begin
                    err_code   <= err_pend;
                    meas_error <= 1'b1;
                    busy       <= 1'b0;
                    proc_ready <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    proc_ready <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sht40_sequencer.sv
// Bench for sht40_sequencer: behavioural i2c_master model, expected results
// queued at stimulus time and checked by an independent output monitor.
module tb_sht40_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        meas_valid;
    logic        meas_error;
    logic [1:0]  err_code;
    logic [15:0] temp_raw;
    logic [15:0] rh_raw;
    logic        proc_ready;
    logic [6:0]  periph_addr;
    logic [7:0]  cmd_frame;
    logic        i2c_writes;
    logic [3:0]  sht_reads;
    logic        crc_error;
    logic [2:0]  master_state;
    logic [3:0]  bytes_received;
    logic [7:0]  data_received;

    always #5 clk = ~clk;

    sht40_sequencer #(
        .MEAS_PERIOD    (24'd1000),
        .TIMEOUT_CYCLES (24'd200)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .meas_valid     (meas_valid),
        .meas_error     (meas_error),
        .err_code       (err_code),
        .temp_raw       (temp_raw),
        .rh_raw         (rh_raw),
        .proc_ready     (proc_ready),
        .periph_addr    (periph_addr),
        .cmd_frame      (cmd_frame),
        .i2c_writes     (i2c_writes),
        .sht_reads      (sht_reads),
        .crc_error      (crc_error),
        .master_state   (master_state),
        .bytes_received (bytes_received),
        .data_received  (data_received)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_err;
        logic [1:0]  err;
        logic [15:0] temp;
        logic [15:0] rh;
        int          crc_pulses;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   crc_seen = 0;

    task automatic push_exp(input logic is_err, input logic [1:0] err,
                            input logic [15:0] temp, input logic [15:0] rh,
                            input int crc_pulses);
        exp_t e;
        e.is_err     = is_err;
        e.err        = err;
        e.temp       = temp;
        e.rh         = rh;
        e.crc_pulses = crc_pulses;
        sbq.push_back(e);
    endtask

    // Monitor: pops one expectation per meas_valid / meas_error pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            crc_seen = 0;
        end else begin
            if (crc_error) crc_seen++;
            if (meas_valid || meas_error) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: valid=%0b error=%0b err_code=%0h, none expected (cycle %0d)",
                             meas_valid, meas_error, err_code, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_is_error", {31'd0, meas_error}, {31'd0, mon_e.is_err});
                    check("out_is_valid", {31'd0, meas_valid}, {31'd0, ~mon_e.is_err});
                    check("err_code", {30'd0, err_code}, {30'd0, mon_e.err});
                    check("temp_raw", {16'd0, temp_raw}, {16'd0, mon_e.temp});
                    check("rh_raw", {16'd0, rh_raw}, {16'd0, mon_e.rh});
                    check("crc_error_cycles", crc_seen, mon_e.crc_pulses);
                end
                crc_seen = 0;
            end
        end
    end

    // ---------------- i2c_master model ----------------
    logic [7:0] m_bytes [8];
    int         m_n = 6;
    int         m_sent = 0;
    bit         m_stuck = 1'b0;
    bit         m_release = 1'b0;
    bit         m_busy = 1'b0;

    task automatic run_txn();
        m_busy = 1'b1;
        m_sent = 0;
        master_state = 3'b001;
        repeat (3) @(negedge clk);
        master_state = 3'b011;
        for (int i = 0; i < m_n; i++) begin
            repeat (2) @(negedge clk);
            data_received  = m_bytes[i];
            bytes_received = bytes_received + 4'd1;
            m_sent = i + 1;
            @(negedge clk);
            data_received = 8'h00;
        end
        while (m_stuck && !m_release) @(negedge clk);
        @(negedge clk);
        master_state = 3'b110;
        @(negedge clk);
        master_state = 3'b000;
        m_busy = 1'b0;
    endtask

    initial begin
        master_state   = 3'b000;
        bytes_received = 4'd13;     // wraps 15->0 during the first transfer
        data_received  = 8'h00;
        forever begin
            @(negedge clk);
            if (proc_ready === 1'b1 && !m_busy) run_txn();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_bytes(input logic [55:0] v, input int n);
        for (int i = 0; i < 7; i++) m_bytes[i] = v[55 - 8*i -: 8];
        m_n = n;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int c = 0;
        while ((busy || m_busy) && c < limit) begin
            @(negedge clk);
            c++;
        end
        check(name, {31'd0, busy | m_busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy_rise(input string name, input int limit);
        int c = 0;
        while (!busy && c < limit) begin
            @(negedge clk);
            c++;
        end
        check(name, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached, got=running want=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    int t_rise1, t_rise2, c;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_proc_ready", {31'd0, proc_ready}, 32'd0);
        check("rst_pulses", {30'd0, meas_valid, meas_error}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_temp", {16'd0, temp_raw}, 32'd0);
        check("rst_rh", {16'd0, rh_raw}, 32'd0);
        check("rst_crc_error", {31'd0, crc_error}, 32'd0);
        check("periph_addr", {25'd0, periph_addr}, 32'h44);
        check("cmd_frame", {24'd0, cmd_frame}, 32'hFD);
        check("i2c_writes", {31'd0, i2c_writes}, 32'd1);
        check("sht_reads", {28'd0, sht_reads}, 32'd5);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good measurement, byte counter wraps 15->0
        set_bytes(56'hBE_EF_92_BE_EF_92_00, 6);
        push_exp(1'b0, 2'b00, 16'hBEEF, 16'hBEEF, 0);
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_idle("t1_idle", 200);

        // 2: bad CRC on first word
        set_bytes(56'hBE_EF_93_BE_EF_92_00, 6);
        push_exp(1'b1, 2'b01, 16'hBEEF, 16'hBEEF, 1);
        pulse_start();
        wait_idle("t2_idle", 200);

        // 3: master gives up after three bytes
        set_bytes(56'hBE_EF_92_00_00_00_00, 3);
        push_exp(1'b1, 2'b11, 16'hBEEF, 16'hBEEF, 0);
        pulse_start();
        wait_idle("t3_idle", 200);

        // 4: bad CRC on second word
        set_bytes(56'hBE_EF_92_BE_EF_93_00, 6);
        push_exp(1'b1, 2'b01, 16'hBEEF, 16'hBEEF, 1);
        pulse_start();
        wait_idle("t4_idle", 200);

        // 5: seventh byte is ignored, distinct humidity word
        set_bytes(56'hBE_EF_92_00_00_81_55, 7);
        push_exp(1'b0, 2'b00, 16'hBEEF, 16'h0000, 0);
        pulse_start();
        wait_idle("t5_idle", 200);

        // 6: master stuck in receive -> timeout
        set_bytes(56'hBE_EF_92_00_00_00_00, 2);
        m_stuck = 1'b1;
        push_exp(1'b1, 2'b10, 16'hBEEF, 16'h0000, 0);
        pulse_start();
        c = 0;
        while (busy && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("t6_busy_fell", {31'd0, busy}, 32'd0);
        check("t6_proc_ready", {31'd0, proc_ready}, 32'd0);
        check("t6_not_early", {31'd0, c >= 190}, 32'd1);
        m_release = 1'b1;
        wait_idle("t6_idle", 50);
        m_release = 1'b0;
        m_stuck = 1'b0;

        // 7: two auto-triggers 1000 cycles apart, start while busy ignored
        set_bytes(56'h00_00_81_BE_EF_92_00, 6);
        push_exp(1'b0, 2'b00, 16'h0000, 16'hBEEF, 0);
        wait_busy_rise("auto1_rise", 1200);
        t_rise1 = cyc;
        repeat (2) @(negedge clk);
        pulse_start();
        wait_idle("auto1_idle", 200);
        set_bytes(56'hBE_EF_92_00_00_81_00, 6);
        push_exp(1'b0, 2'b00, 16'hBEEF, 16'h0000, 0);
        wait_busy_rise("auto2_rise", 1100);
        t_rise2 = cyc;
        check("auto_period", t_rise2 - t_rise1, 32'd1000);
        wait_idle("auto2_idle", 200);

        // 8: reset mid-transfer, then a clean measurement
        set_bytes(56'hBE_EF_92_BE_EF_92_00, 6);
        pulse_start();
        c = 0;
        while (m_sent < 2 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("t8_mid_transfer", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t8_rst_busy", {31'd0, busy}, 32'd0);
        check("t8_rst_proc_ready", {31'd0, proc_ready}, 32'd0);
        check("t8_rst_temp", {16'd0, temp_raw}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (m_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        push_exp(1'b0, 2'b00, 16'hBEEF, 16'hBEEF, 0);
        pulse_start();
        wait_idle("t8_idle", 200);

        check("sb_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
